// File: rtl/falling_cubes_pixel_gen.sv
// Four cubes fall down fixed 160-pixel lanes and are drawn over a flat background for a 640x480 VGA scan.
// Latency: rgb is registered 1 clk after the p_tick that presents the pixel; frame_tick follows its p_tick by 1 clk.
// Backpressure: none. Sync-generator timing is consumed as-is; pause only freezes motion and the drop counter.
`timescale 1ns/1ps
module falling_cubes_pixel_gen #(
    parameter int          CUBE_SIZE = 16,
    parameter int          SPEED     = 2,
    parameter logic [9:0]  LFSR_SEED = 10'h2A5,
    parameter logic [11:0] BG_COLOR  = 12'h112
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [7:0]  cubes_dropped
);

    localparam int          NCUBES      = 4;
    localparam int          LANE_W      = 160;
    localparam int          X_INIT_OFF  = 72;
    localparam int          Y_INIT_STEP = 120;
    localparam logic [10:0] V_ACTIVE    = 11'd480;
    localparam logic [10:0] CS11        = 11'(CUBE_SIZE);
    localparam logic [10:0] SPD11       = 11'(SPEED);
    localparam logic [NCUBES*12-1:0] CUBE_COLORS = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};

    logic [9:0]  lfsr_q, lfsr_d;
    logic [9:0]  x_q [NCUBES];
    logic [9:0]  x_d [NCUBES];
    logic [8:0]  y_q [NCUBES];
    logic [8:0]  y_d [NCUBES];
    logic [11:0] rgb_q, rgb_d;
    logic        frame_tick_q;
    logic [7:0]  drop_q, drop_d;

    logic        frame_pre;
    logic        move_en;
    logic [NCUBES-1:0] respawn;
    logic [2:0]  respawn_cnt;
    logic [8:0]  drop_sum;
    logic [11:0] pix_rgb;
    logic [10:0] px11, py11;

    function automatic logic [6:0] rotl7(input logic [6:0] v, input int s);
        logic [13:0] d;
        d = {v, v} << s;
        return d[13:7];
    endfunction

    function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo);
        return (p >= lo) && (p < lo + CS11);
    endfunction

    // Fibonacci form of x^10 + x^7 + 1: taps on the two MSB-side stages 10 and 7.
    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    assign frame_pre = p_tick & (pixel_x == 10'd0) & (pixel_y == 10'd480);
    assign move_en   = frame_tick_q & ~pause;

    always_comb begin
        respawn_cnt = '0;
        respawn     = '0;
        for (int i = 0; i < NCUBES; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if (move_en) begin
                if ({2'b00, y_q[i]} + SPD11 >= V_ACTIVE) begin
                    respawn[i] = 1'b1;
                    y_d[i]     = '0;
                    // 7-bit offset keeps the cube inside its own lane.
                    x_d[i]     = 10'(LANE_W * i) + {3'b000, rotl7(lfsr_q[6:0], 2 * i)};
                end else begin
                    y_d[i] = y_q[i] + 9'(SPEED);
                end
            end
            respawn_cnt = respawn_cnt + 3'(respawn[i]);
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + {6'b000000, respawn_cnt};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    assign px11 = {1'b0, pixel_x};
    assign py11 = {1'b0, pixel_y};

    // Scan from the highest index down so the lowest-numbered hit wins.
    always_comb begin
        pix_rgb = BG_COLOR;
        for (int i = NCUBES - 1; i >= 0; i--) begin
            if (in_span(px11, {1'b0, x_q[i]}) && in_span(py11, {2'b00, y_q[i]})) begin
                pix_rgb = CUBE_COLORS[i*12 +: 12];
            end
        end
    end

    always_comb begin
        rgb_d = rgb_q;
        if (p_tick) begin
            rgb_d = video_on ? pix_rgb : 12'h000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= LFSR_SEED;
            rgb_q        <= '0;
            frame_tick_q <= 1'b0;
            drop_q       <= '0;
            for (int i = 0; i < NCUBES; i++) begin
                x_q[i] <= 10'(LANE_W * i + X_INIT_OFF);
                y_q[i] <= 9'(Y_INIT_STEP * i);
            end
        end else begin
            lfsr_q       <= lfsr_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_pre;
            drop_q       <= drop_d;
            for (int i = 0; i < NCUBES; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign rgb           = rgb_q;
    assign frame_tick    = frame_tick_q;
    assign cubes_dropped = drop_q;

endmodule

// File: tb/tb_falling_cubes_pixel_gen.sv
// Directed bench for falling_cubes_pixel_gen: a behavioural cube model predicts each pixel,
// expected colours are queued at drive time and popped when the registered rgb appears.
`timescale 1ns/1ps
module tb_falling_cubes_pixel_gen;

    localparam logic [9:0] SEED = 10'h2A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pause;
    logic [11:0] rgb;
    logic        frame_tick;
    logic [7:0]  cubes_dropped;

    int checks = 0;
    int errors = 0;

    int xm [4];
    int ym [4];
    int cm;
    logic [9:0]  lfsr_m;
    logic [11:0] exp_q [$];
    logic [11:0] last_rgb;

    falling_cubes_pixel_gen dut (
        .clk           (clk),
        .reset         (reset),
        .p_tick        (p_tick),
        .video_on      (video_on),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .pause         (pause),
        .rgb           (rgb),
        .frame_tick    (frame_tick),
        .cubes_dropped (cubes_dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) lfsr_m <= SEED;
        else       lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] colour(input int i);
        case (i)
            0:       return 12'hF00;
            1:       return 12'h0F0;
            2:       return 12'h00F;
            default: return 12'hFF0;
        endcase
    endfunction

    function automatic logic [11:0] model_rgb(input int px, input int py, input bit von);
        if (!von) return 12'h000;
        for (int i = 0; i < 4; i++)
            if (px >= xm[i] && px < xm[i] + 16 && py >= ym[i] && py < ym[i] + 16)
                return colour(i);
        return 12'h112;
    endfunction

    function automatic int rot_off(input logic [6:0] v, input int s);
        logic [6:0] r;
        r = v;
        for (int k = 0; k < s; k++) r = {r[5:0], r[6]};
        return int'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            xm[i] = 160 * i + 72;
            ym[i] = 120 * i;
        end
        cm = 0;
    endtask

    task automatic model_move();
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (ym[i] + 2 >= 480) begin
                ym[i] = 0;
                xm[i] = 160 * i + rot_off(lfsr_m[6:0], 2 * i);
                n++;
            end else begin
                ym[i] = ym[i] + 2;
            end
        end
        cm = (cm + n > 255) ? 255 : cm + n;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pix(input string tag, input int px, input int py, input bit von);
        logic [11:0] e;
        @(negedge clk);
        p_tick   = 1'b1;
        pixel_x  = 10'(px);
        pixel_y  = 10'(py);
        video_on = von;
        exp_q.push_back(model_rgb(px, py, von));
        @(negedge clk);
        p_tick = 1'b0;
        e = exp_q.pop_front();
        last_rgb = e;
        chk(tag, rgb, e);
    endtask

    task automatic frame(input bit pz, input bit chk_cnt);
        @(negedge clk);
        p_tick   = 1'b1;
        pixel_x  = 10'd0;
        pixel_y  = 10'd480;
        video_on = 1'b0;
        pause    = pz;
        @(negedge clk);
        p_tick = 1'b0;
        chk("ftick_hi", {11'd0, frame_tick}, 12'd1);
        if (!pz) model_move();
        @(negedge clk);
        chk("ftick_lo", {11'd0, frame_tick}, 12'd0);
        if (chk_cnt) chk("drops", {4'd0, cubes_dropped}, 12'(cm));
    endtask

    initial begin
        reset = 1'b1; p_tick = 1'b0; video_on = 1'b0;
        pixel_x = '0; pixel_y = '0; pause = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        p_tick = 1'b1; video_on = 1'b1; pixel_x = 10'd72; pixel_y = 10'd0;
        @(negedge clk);
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_ftick", {11'd0, frame_tick}, 12'd0);
        chk("rst_drops", {4'd0, cubes_dropped}, 12'd0);
        p_tick = 1'b0;
        reset  = 1'b0;

        // Initial placement and cube edges.
        pix("c0_left",   72, 0, 1);
        pix("c0_left-1", 71, 0, 1);
        pix("c0_right",  87, 15, 1);
        pix("c0_right+1", 88, 0, 1);
        pix("c0_below",  72, 16, 1);
        pix("c1_in",     232, 120, 1);
        pix("c1_bot+1",  232, 136, 1);
        pix("c2_in",     392, 250, 1);
        pix("c3_in",     560, 370, 1);
        pix("c1_blank",  232, 120, 0);

        // rgb must hold while p_tick is low even if the pixel moves into a cube.
        @(negedge clk);
        pixel_x = 10'd72; pixel_y = 10'd0; video_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("hold", rgb, last_rgb);

        // Right coordinates without p_tick must not make a frame tick.
        pixel_x = 10'd0; pixel_y = 10'd480;
        @(negedge clk);
        @(negedge clk);
        chk("no_ptick", {11'd0, frame_tick}, 12'd0);

        pix("pre_y1",  72, 1, 1);
        pix("pre_y16", 72, 16, 1);
        frame(1'b0, 1'b1);
        pix("post_y1",  72, 1, 1);
        pix("post_y16", 72, 16, 1);
        pix("post_y17", 72, 17, 1);
        pix("post_y18", 72, 18, 1);

        // Bring cube 0 to y=478, then one more frame wraps it.
        for (int f = 0; f < 238; f++) frame(1'b0, 1'b1);
        pix("c0_y478", xm[0], 478, 1);
        frame(1'b0, 1'b1);
        pix("c0_resp_in",  xm[0], 0, 1);
        pix("c0_resp_r+1", xm[0] + 16, 0, 1);
        if (xm[0] > 0) pix("c0_resp_l-1", xm[0] - 1, 0, 1);
        pix("c0_old_pos", 72, 479, 1);

        // Paused frames still tick but nothing moves.
        pix("c1_bot_edge", xm[1], ym[1] + 15, 1);
        pix("c1_bot+1_pre", xm[1], ym[1] + 16, 1);
        for (int f = 0; f < 3; f++) frame(1'b1, 1'b1);
        pause = 1'b0;
        pix("c1_bot_edge_p", xm[1], ym[1] + 15, 1);
        pix("c1_bot+1_p",    xm[1], ym[1] + 16, 1);

        for (int f = 0; f < 15400; f++) frame(1'b0, 1'b1);
        chk("sat", {4'd0, cubes_dropped}, 12'd255);

        // Reset in the middle of a line wins over a live p_tick.
        @(negedge clk);
        reset = 1'b1; p_tick = 1'b1; video_on = 1'b1;
        pixel_x = 10'd72; pixel_y = 10'd0;
        @(negedge clk);
        reset = 1'b0; p_tick = 1'b0;
        model_reset();
        chk("mid_rst_rgb", rgb, 12'h000);
        chk("mid_rst_drops", {4'd0, cubes_dropped}, 12'd0);
        pix("after_rst_c0", 72, 0, 1);
        pix("after_rst_c1", 232, 120, 1);
        pix("after_rst_bg", 71, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
